// File: rtl/cpu_core.sv
// cpu_core: multi-cycle 16-bit datapath controlled by an eight-state FSM.
// Executes MOV #imm8, MOV reg, ADD, CMP, AND and MVN from an instruction
// register loaded independently of the FSM.
//
// Ports:
//   clk    - rising-edge clock for all state
//   reset  - asynchronous active-low reset
//   s      - start, sampled only while waiting
//   load   - instruction register load enable
//   in     - 16-bit instruction word
//   out    - result register C
//   N,V,Z  - status flags (negative, signed overflow, zero)
//   w      - high while the FSM is waiting for a start
module cpu_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        N,
    output logic        V,
    output logic        Z,
    output logic        w
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GETA,
        S_GETB,
        S_ALU,
        S_CMP,
        S_WRITEREG,
        S_WRITEIMM
    } state_t;

    state_t      state_q;
    logic [15:0] ir_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] c_q;
    logic [2:0]  status_q;   // {N, V, Z}
    logic        w_q;
    logic [15:0] rf_q [8];

    // Instruction fields
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic [15:0] sximm8;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_alu_grp;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu_grp = (opcode == 3'b101);

    // Single register-file read port: Rn while fetching A, Rm otherwise.
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;

    assign rd_addr = (state_q == S_GETA) ? rn : rm;
    assign rd_data = rf_q[rd_addr];

    // Shifter, ALU and flag generation
    logic [15:0] b_shift;
    logic [15:0] ain;
    logic [1:0]  aluop;
    logic [15:0] alu_d;
    logic [2:0]  status_d;

    always_comb begin
        b_shift = b_q;
        unique case (sh)
            2'b00: b_shift = b_q;
            2'b01: b_shift = {b_q[14:0], 1'b0};
            2'b10: b_shift = {1'b0, b_q[15:1]};
            2'b11: b_shift = {b_q[15], b_q[15:1]};
            default: b_shift = b_q;
        endcase
    end

    always_comb begin
        ain   = is_mov_reg ? '0 : a_q;
        aluop = is_mov_reg ? 2'b00 : op;
        alu_d = '0;
        unique case (aluop)
            2'b00: alu_d = ain + b_shift;
            2'b01: alu_d = ain - b_shift;
            2'b10: alu_d = ain & b_shift;
            2'b11: alu_d = ~b_shift;
            default: alu_d = '0;
        endcase
        // Overflow is only meaningful for the subtract used by CMP.
        status_d = {alu_d[15],
                    (ain[15] != b_shift[15]) && (alu_d[15] != ain[15]),
                    (alu_d == 16'h0000)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_WAIT;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
            w_q      <= 1'b1;
            for (int unsigned i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (load) begin
                ir_q <= in;
            end
            unique case (state_q)
                S_WAIT: begin
                    if (s) begin
                        state_q <= S_DECODE;
                        w_q     <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (is_mov_imm) begin
                        state_q <= S_WRITEIMM;
                    end else if (is_alu_grp && (op != 2'b11)) begin
                        state_q <= S_GETA;
                    end else if ((is_alu_grp && (op == 2'b11)) || is_mov_reg) begin
                        state_q <= S_GETB;
                    end else begin
                        state_q <= S_WAIT;
                        w_q     <= 1'b1;
                    end
                end
                S_GETA: begin
                    a_q     <= rd_data;
                    state_q <= S_GETB;
                end
                S_GETB: begin
                    b_q     <= rd_data;
                    state_q <= (is_alu_grp && (op == 2'b01)) ? S_CMP : S_ALU;
                end
                S_ALU: begin
                    c_q     <= alu_d;
                    state_q <= S_WRITEREG;
                end
                S_CMP: begin
                    status_q <= status_d;
                    state_q  <= S_WAIT;
                    w_q      <= 1'b1;
                end
                S_WRITEREG: begin
                    rf_q[rd] <= c_q;
                    state_q  <= S_WAIT;
                    w_q      <= 1'b1;
                end
                S_WRITEIMM: begin
                    rf_q[rn] <= sximm8;
                    state_q  <= S_WAIT;
                    w_q      <= 1'b1;
                end
                default: begin
                    state_q <= S_WAIT;
                    w_q     <= 1'b1;
                end
            endcase
        end
    end

    assign out = c_q;
    assign N   = status_q[2];
    assign V   = status_q[1];
    assign Z   = status_q[0];
    assign w   = w_q;

endmodule

// File: tb/tb_cpu_core.sv
module tb_cpu_core;

    logic        clk;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic [15:0] out;
    logic        N;
    logic        V;
    logic        Z;
    logic        w;

    int checks   = 0;
    int failures = 0;

    // Architectural reference state
    logic [15:0] m_r [8];
    logic [15:0] m_c;
    logic        m_n;
    logic        m_v;
    logic        m_z;

    cpu_core dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .load  (load),
        .in    (in),
        .out   (out),
        .N     (N),
        .V     (V),
        .Z     (Z),
        .w     (w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
        m_c = 16'h0000;
        m_n = 1'b0;
        m_v = 1'b0;
        m_z = 1'b0;
    endtask

    // Executes one instruction on the reference state; returns the expected
    // number of edges until w rises and whether C is written by it.
    task automatic model_exec(input logic [15:0] ir, output int lat, output bit writes_c);
        logic [2:0]  opc;
        logic [1:0]  op;
        logic [2:0]  rn, rd, rm;
        logic [1:0]  sh;
        logic [15:0] bv, bs, res;
        int          sa, sb, diff;
        opc = ir[15:13];
        op  = ir[12:11];
        rn  = ir[10:8];
        rd  = ir[7:5];
        sh  = ir[4:3];
        rm  = ir[2:0];
        bv  = m_r[rm];
        case (sh)
            2'd0: bs = bv;
            2'd1: bs = bv << 1;
            2'd2: bs = bv >> 1;
            default: bs = 16'($signed(bv) >>> 1);
        endcase
        writes_c = 1'b0;
        if (opc == 3'd6 && op == 2'd2) begin
            m_r[rn] = {{8{ir[7]}}, ir[7:0]};
            lat = 3;
        end else if (opc == 3'd6 && op == 2'd0) begin
            m_c = bs;
            m_r[rd] = bs;
            writes_c = 1'b1;
            lat = 5;
        end else if (opc == 3'd5) begin
            case (op)
                2'd0: begin res = m_r[rn] + bs; lat = 6; end
                2'd2: begin res = m_r[rn] & bs; lat = 6; end
                2'd3: begin res = ~bs;          lat = 5; end
                default: begin
                    sa   = $signed(m_r[rn]);
                    sb   = $signed(bs);
                    diff = sa - sb;
                    res  = diff[15:0];
                    m_n  = res[15];
                    m_z  = (res == 16'h0000);
                    m_v  = (diff > 32767) || (diff < -32768);
                    lat  = 5;
                end
            endcase
            if (op != 2'd1) begin
                m_c = res;
                m_r[rd] = res;
                writes_c = 1'b1;
            end
        end else begin
            lat = 2;
        end
    endtask

    task automatic run_instr(input logic [15:0] ir, input string tag);
        int          lat_exp;
        bit          writes_c;
        int          edges;
        logic [15:0] out_alu;
        model_exec(ir, lat_exp, writes_c);
        out_alu = 16'hxxxx;
        @(negedge clk);
        in   = ir;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        s    = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        s = 1'b0;
        while (w !== 1'b1 && edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == lat_exp - 1) out_alu = out;
        end
        check({tag, "_latency"}, edges, lat_exp);
        if (writes_c) check({tag, "_out_at_alu"}, {16'h0, out_alu}, {16'h0, m_c});
        check({tag, "_out"}, {16'h0, out}, {16'h0, m_c});
        check({tag, "_nvz"}, {29'h0, N, V, Z}, {29'h0, m_n, m_v, m_z});
    endtask

    // Observe a register architecturally with MOV Rk,Rk (value is unchanged).
    task automatic read_reg(input int k, input logic [15:0] exp, input string tag);
        logic [2:0] r;
        r = 3'(k);
        run_instr({3'b110, 2'b00, 3'b000, r, 2'b00, r}, tag);
        check({tag, "_val"}, {16'h0, out}, {16'h0, exp});
    endtask

    initial begin
        logic [15:0] ir;
        int          kind;
        reset = 1'b0;
        s     = 1'b0;
        load  = 1'b0;
        in    = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_out", {16'h0, out}, 32'h0);
        check("reset_nvz", {29'h0, N, V, Z}, 32'h0);
        check("reset_w", {31'h0, w}, 32'h1);

        run_instr(16'hD007, "mov_r0_7");
        read_reg(0, 16'h0007, "read_r0");
        run_instr(16'hD102, "mov_r1_2");
        read_reg(1, 16'h0002, "read_r1");
        run_instr(16'hA148, "add_lsl");
        check("add_val", {16'h0, out}, 32'h0010);
        read_reg(2, 16'h0010, "read_r2");
        run_instr(16'hA900, "cmp_r1_r0");
        check("cmp_neg_flags", {29'h0, N, V, Z}, 32'h4);
        run_instr(16'hA800, "cmp_r0_r0");
        check("cmp_eq_flags", {29'h0, N, V, Z}, 32'h1);
        run_instr(16'hB860, "mvn_r3");
        check("mvn_val", {16'h0, out}, 32'hFFF8);
        run_instr(16'hC090, "mov_lsr");
        check("mov_lsr_val", {16'h0, out}, 32'h0003);
        run_instr(16'h0123, "invalid_op");

        // Abort an ADD in GETB with reset
        @(negedge clk);
        in   = 16'hA148;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        s    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_w", {31'h0, w}, 32'h1);
        check("abort_out", {16'h0, out}, 32'h0);
        check("abort_nvz", {29'h0, N, V, Z}, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        read_reg(2, 16'h0000, "abort_r2");

        // Randomized instruction stream
        for (int i = 0; i < 250; i++) begin
            kind = int'($urandom_range(0, 6));
            ir   = 16'($urandom);
            case (kind)
                0: ir[15:11] = 5'b11010;
                1: ir[15:11] = 5'b11000;
                2: ir[15:11] = 5'b10100;
                3: ir[15:11] = 5'b10101;
                4: ir[15:11] = 5'b10110;
                5: ir[15:11] = 5'b10111;
                default: ;
            endcase
            run_instr(ir, "rand");
        end
        for (int k = 0; k < 8; k++) read_reg(k, m_r[k], "final_reg");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
